hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Scoreboard-based hazard controller sequencing the decode-to-execute hand-off.
- Tracks in-flight destination registers (Rc) from issue until writeback.
- Stalls the decode/fetch stages while a source operand (Ra, or Rb when register-sourced) is still pending, and marks the held slot in execute as a bubble.
- Sits beside the decode stage; consumes the same instruction word decode sees.

Parameters:
- WB_LAT, 3, cycles from issue (decode→execute register update) until the result is visible in the register file; range 1..7.
- CNT_W, 3, width of each per-register countdown; must hold WB_LAT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- instr_decode  input  32  instruction currently in decode; field layout {Imb[31], Ra[30:27], Imm[26:13], Opc[12:8], Rc[7:4], Cond[3:1], Cmp[0]}, Rb = [26:23]
- flush  input  1  discard the instruction in decode (taken branch / pc write)
- stall  output  1  combinational; hold fetch and decode this cycle
- exec_valid  output  1  registered; instruction now in execute is real (0 = bubble)
- busy_mask  output  14  registered; bit n set while r[n] has a pending write
- stall_cnt  output  16  see Optional Feature

Behaviour:
- Reset (rst low, asynchronous): all counters = 0, busy_mask = 0, exec_valid = 0, stall_cnt = 0. stall is combinational, so it is 0 while counters are 0.
- Decode classification:
  - instr_decode == 32'h0 is a NOP: no sources, no destination.
  - Ra source is tracked only for Ra < 14. Ra 14 (pc) and Ra 15 (overflow) never hazard.
  - Rb source is tracked only when Imb = 0 and Rb < 14.
  - Destination Rc is tracked only for Rc < 14 and non-NOP instructions.
- Hazard condition: a tracked source register whose counter is non-zero.
- stall = hazard && !flush. Flush overrides stall because the instruction is being discarded anyway.
- Issue: occurs on any cycle with stall = 0, flush = 0 and a non-NOP instruction.
  - On issue, cnt[Rc] <= WB_LAT next edge (when Rc is tracked).
- Countdown: every cycle, each non-zero counter decrements by 1, except the counter being reloaded by issue. Reload wins over decrement, including an Rc equal to a source that is counting down (WAW).
- busy_mask[n] <= (next cnt[n] != 0). It is registered in the same edge as the counters.
- exec_valid <= issue. A stall cycle or flush cycle yields exec_valid = 0 next cycle, because decode holds or repeats its outputs and execute must ignore them.
- Latency:
  - A dependent instruction immediately following its producer stalls exactly WB_LAT cycles, then issues.
  - Example, WB_LAT = 3: stall high for 3 cycles, issue on the 4th.
- Boundary cases:
  - Ra == Rb, both pending: single hazard, same stall length.
  - Source equal to own Rc (e.g. r3 <= r3 + x) with r3 not pending: no stall; mark after issue.
  - flush during a stall: stall drops that cycle, no mark, exec_valid = 0 next cycle. Pending counters continue, because instructions already in execute still write back.
  - Reset asserted mid-stall: all state clears immediately; stall drops once rst is low (counters zero).
- No arithmetic wrap: counters saturate at 0.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: stall_cnt increments by 1 on every cycle with stall = 1, saturating at 16'hFFFF. It is cleared only by reset.
- Undefined: stall_cnt is tied to 16'h0 and no counter logic is generated. The port remains so the interface is fixed.

Test Plan:
- Reset, then issue r2 <= r0 + r1 (Imb = 0, Ra = 0, Rb = 1, Rc = 2) → next cycle exec_valid = 1, busy_mask = 14'h0004, stall = 0.
- Producer Rc = 5, then immediately consumer with Ra = 5, WB_LAT = 3 → stall = 1 for exactly 3 cycles, exec_valid = 0 those cycles, consumer issues on cycle 4, busy_mask bit 5 clears coincident.
- Immediate consumer (Imb = 1) whose Imm[26:23] bits equal a pending register number → no stall; Ra = 14 or 15 with any pending register → no stall.
- Consumer stalled on r7, assert flush in the 2nd stall cycle → stall = 0 that cycle, exec_valid = 0 next, r7 counter continues to 0 on schedule, no new mark.
- Back-to-back writes to r4 (WAW), then a reader of r4 → counter reloads to WAW value, reader stalls WB_LAT cycles from the second write.
- Assert rst low mid-stall with HAZARD_STATS_EN defined after 2 stall cycles (stall_cnt = 2) → stall_cnt = 0, busy_mask = 0, exec_valid = 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Scoreboard-based hazard controller for the decode-to-execute hand-off.
// Every architectural register r0..r13 owns a small countdown that is loaded
// with WB_LAT when an instruction writing that register issues. The countdown
// reaches zero on the cycle the result becomes visible in the register file.
// While a source operand of the instruction in decode still has a non-zero
// countdown, fetch and decode are held and execute receives a bubble.
//
// Optional build macro: HAZARD_STATS_EN
//   defined   : stall_cnt counts stall cycles, saturating at 16'hFFFF
//   undefined : stall_cnt is tied to zero and no counter is built
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-low reset
//   instr_decode in   instruction in decode:
//                     {Imb[31], Ra[30:27], Imm[26:13], Opc[12:8], Rc[7:4],
//                      Cond[3:1], Cmp[0]}, with Rb = [26:23]
//   flush        in   discard the instruction in decode
//   stall        out  combinational; hold fetch and decode this cycle
//   exec_valid   out  registered; 1 = instruction in execute is real
//   busy_mask    out  registered; bit n set while r[n] has a pending write
//   stall_cnt    out  stall-cycle counter (see macro note above)
//
// Hand-off rule: decode presents an instruction every cycle. It is accepted
// (issued) on a cycle with stall = 0 and flush = 0 and a non-NOP word; any
// other cycle puts a bubble into execute on the next edge.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int WB_LAT = 3,
    parameter int CNT_W  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_decode,
    input  logic        flush,
    output logic        stall,
    output logic        exec_valid,
    output logic [13:0] busy_mask,
    output logic [15:0] stall_cnt
);

    localparam int NREG = 14;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WB_LAT);

    // Instruction fields
    logic       imb;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_nop;

    assign imb    = instr_decode[31];
    assign ra     = instr_decode[30:27];
    assign rb     = instr_decode[26:23];
    assign rc     = instr_decode[7:4];
    assign is_nop = (instr_decode == 32'h0);

    // Fields that do not influence hazard decisions
    logic unused_fields;
    assign unused_fields = ^{instr_decode[22:8], instr_decode[3:0]};

    // Source/destination classification. r14 (pc) and r15 (overflow) are
    // never tracked.
    logic ra_trk;
    logic rb_trk;
    logic rc_trk;

    assign ra_trk = !is_nop && (ra < 4'd14);
    assign rb_trk = !is_nop && !imb && (rb < 4'd14);
    assign rc_trk = !is_nop && (rc < 4'd14);

    // Per-register countdowns
    logic [CNT_W-1:0] cnt      [NREG];
    logic [CNT_W-1:0] cnt_next [NREG];
    logic [NREG-1:0]  pend;
    logic [15:0]      pend16;

    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            pend[n] = (cnt[n] != '0);
        end
    end

    // Padded to 16 entries so the 4-bit field indexes it without range
    // concerns; the two top entries (pc, overflow) are always clear.
    assign pend16 = {2'b00, pend};

    logic hazard;
    logic issue;

    assign hazard = (ra_trk && pend16[ra]) || (rb_trk && pend16[rb]);
    assign stall  = hazard && !flush;
    assign issue  = !hazard && !flush && !is_nop;

    // Reload beats decrement, so a WAW rewrite restarts the full latency.
    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            cnt_next[n] = cnt[n];
            if (issue && rc_trk && (rc == 4'(n))) begin
                cnt_next[n] = LOAD_VAL;
            end else if (cnt[n] != '0) begin
                cnt_next[n] = cnt[n] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NREG; n++) begin
                cnt[n] <= '0;
            end
            busy_mask  <= '0;
            exec_valid <= 1'b0;
        end else begin
            for (int n = 0; n < NREG; n++) begin
                cnt[n]       <= cnt_next[n];
                busy_mask[n] <= (cnt_next[n] != '0);
            end
            exec_valid <= issue;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'h0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h1;
        end
    end
`else
    assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl (WB_LAT = 3). Inputs are driven 1 ns after
// the rising edge; outputs are observed on the falling edge, so stall reflects
// the current decode word and registered outputs reflect the last edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr_decode;
    logic        flush;
    logic        stall;
    logic        exec_valid;
    logic [13:0] busy_mask;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0;

    hazard_ctrl #(.WB_LAT(3), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_decode (instr_decode),
        .flush        (flush),
        .stall        (stall),
        .exec_valid   (exec_valid),
        .busy_mask    (busy_mask),
        .stall_cnt    (stall_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [31:0] mk(input logic imb, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        mk = {imb, ra, rb, 10'h0, 5'h01, rc, 4'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic st, input logic ev,
                             input logic [13:0] bm);
        check({tag, ".stall"}, 32'(stall), 32'(st));
        check({tag, ".exec_valid"}, 32'(exec_valid), 32'(ev));
        check({tag, ".busy_mask"}, 32'(busy_mask), 32'(bm));
    endtask

    task automatic check_stats(input string tag, input logic [15:0] exp_on);
`ifdef HAZARD_STATS_EN
        check(tag, 32'(stall_cnt), 32'(exp_on));
`else
        check(tag, 32'(stall_cnt), 32'(16'h0 & exp_on));
`endif
    endtask

    // Advance one cycle: drive after the edge, land on the falling edge.
    task automatic step(input logic [31:0] ins, input logic fl);
        @(posedge clk);
        #1;
        instr_decode = ins;
        flush        = fl;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b0;
        instr_decode = NOP;
        flush        = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 1'b0, 1'b0, 14'h0);
        check_stats("reset.stall_cnt", 16'd0);
        rst = 1'b1;

        // T1: r2 <= r0 + r1
        step(mk(1'b0, 4'd0, 4'd1, 4'd2), 1'b0);
        check("t1.no_stall", 32'(stall), 32'd0);
        step(NOP, 1'b0);
        check_out("t1.issued", 1'b0, 1'b1, 14'h0004);
        step(NOP, 1'b0);
        step(NOP, 1'b0);
        check("t1.still_busy", 32'(busy_mask), 32'h0004);
        step(NOP, 1'b0);
        check_out("t1.drained", 1'b0, 1'b0, 14'h0);

        // T2: producer r5, then immediate consumer of r5 (writes r6)
        step(mk(1'b0, 4'd0, 4'd1, 4'd5), 1'b0);
        check("t2.prod", 32'(stall), 32'd0);
        step(mk(1'b1, 4'd5, 4'd0, 4'd6), 1'b0);
        check_out("t2.stall1", 1'b1, 1'b1, 14'h0020);
        step(mk(1'b1, 4'd5, 4'd0, 4'd6), 1'b0);
        check_out("t2.stall2", 1'b1, 1'b0, 14'h0020);
        step(mk(1'b1, 4'd5, 4'd0, 4'd6), 1'b0);
        check_out("t2.stall3", 1'b1, 1'b0, 14'h0020);
        step(mk(1'b1, 4'd5, 4'd0, 4'd6), 1'b0);
        check_out("t2.release", 1'b0, 1'b0, 14'h0);
        step(NOP, 1'b0);
        check_out("t2.issued", 1'b0, 1'b1, 14'h0040);
        check_stats("t2.stall_cnt", 16'd3);
        repeat (3) step(NOP, 1'b0);
        check("t2.drained", 32'(busy_mask), 32'h0);

        // T3: immediate operand bits and pc/overflow sources never hazard
        step(mk(1'b0, 4'd0, 4'd1, 4'd9), 1'b0);
        step(mk(1'b1, 4'd0, 4'd9, 4'd10), 1'b0);
        check("t3.imm_no_stall", 32'(stall), 32'd0);
        step(mk(1'b1, 4'd14, 4'd0, 4'd11), 1'b0);
        check("t3.ra14_no_stall", 32'(stall), 32'd0);
        step(mk(1'b0, 4'd15, 4'd0, 4'd12), 1'b0);
        check("t3.ra15_no_stall", 32'(stall), 32'd0);
        check("t3.busy", 32'(busy_mask), 32'h0E00);
        repeat (4) step(NOP, 1'b0);
        check("t3.drained", 32'(busy_mask), 32'h0);

        // T3b: r3 <= r3 + r0 with r3 free: no stall, marked after issue
        step(mk(1'b0, 4'd3, 4'd0, 4'd3), 1'b0);
        check("t3b.no_stall", 32'(stall), 32'd0);
        step(NOP, 1'b0);
        check_out("t3b.marked", 1'b0, 1'b1, 14'h0008);
        repeat (3) step(NOP, 1'b0);

        // T4: flush in the 2nd stall cycle of a consumer of r7
        step(mk(1'b0, 4'd0, 4'd1, 4'd7), 1'b0);
        step(mk(1'b0, 4'd7, 4'd0, 4'd8), 1'b0);
        check_out("t4.stall1", 1'b1, 1'b1, 14'h0080);
        step(mk(1'b0, 4'd7, 4'd0, 4'd8), 1'b1);
        check("t4.flush_drops_stall", 32'(stall), 32'd0);
        step(NOP, 1'b0);
        check_out("t4.after_flush", 1'b0, 1'b0, 14'h0080);
        step(NOP, 1'b0);
        check_out("t4.r7_done", 1'b0, 1'b0, 14'h0);
        check_stats("t4.stall_cnt", 16'd4);

        // T5: WAW on r4, then reader of r4 stalls 3 cycles from second write
        step(mk(1'b0, 4'd0, 4'd1, 4'd4), 1'b0);
        step(mk(1'b0, 4'd0, 4'd1, 4'd4), 1'b0);
        check("t5.w2_no_stall", 32'(stall), 32'd0);
        step(mk(1'b1, 4'd4, 4'd0, 4'd3), 1'b0);
        check_out("t5.stall1", 1'b1, 1'b1, 14'h0010);
        step(mk(1'b1, 4'd4, 4'd0, 4'd3), 1'b0);
        check("t5.stall2", 32'(stall), 32'd1);
        step(mk(1'b1, 4'd4, 4'd0, 4'd3), 1'b0);
        check_out("t5.stall3", 1'b1, 1'b0, 14'h0010);
        step(mk(1'b1, 4'd4, 4'd0, 4'd3), 1'b0);
        check_out("t5.release", 1'b0, 1'b0, 14'h0);
        step(NOP, 1'b0);
        check_out("t5.issued", 1'b0, 1'b1, 14'h0008);
        repeat (3) step(NOP, 1'b0);
        check_stats("t5.stall_cnt", 16'd7);

        // T6: Ra == Rb both on pending r6: single hazard, 3 stall cycles
        step(mk(1'b0, 4'd0, 4'd1, 4'd6), 1'b0);
        step(mk(1'b0, 4'd6, 4'd6, 4'd9), 1'b0);
        check("t6.stall1", 32'(stall), 32'd1);
        step(mk(1'b0, 4'd6, 4'd6, 4'd9), 1'b0);
        step(mk(1'b0, 4'd6, 4'd6, 4'd9), 1'b0);
        check("t6.stall3", 32'(stall), 32'd1);
        step(mk(1'b0, 4'd6, 4'd6, 4'd9), 1'b0);
        check("t6.release", 32'(stall), 32'd0);
        step(NOP, 1'b0);
        check_out("t6.issued", 1'b0, 1'b1, 14'h0200);
        repeat (3) step(NOP, 1'b0);
        check_stats("t6.stall_cnt", 16'd10);

        // T7: asynchronous reset in the middle of a stall
        step(mk(1'b0, 4'd0, 4'd1, 4'd7), 1'b0);
        step(mk(1'b1, 4'd7, 4'd0, 4'd8), 1'b0);
        step(mk(1'b1, 4'd7, 4'd0, 4'd8), 1'b0);
        step(mk(1'b1, 4'd7, 4'd0, 4'd8), 1'b0);
        check("t7.pre_stall", 32'(stall), 32'd1);
        check_stats("t7.pre_stall_cnt", 16'd12);
        rst = 1'b0;
        #1;
        check_out("t7.async_reset", 1'b0, 1'b0, 14'h0);
        check_stats("t7.reset_stall_cnt", 16'd0);
        @(negedge clk);
        rst = 1'b1;
        step(mk(1'b1, 4'd7, 4'd0, 4'd8), 1'b0);
        check("t7.no_stall_after_reset", 32'(stall), 32'd0);
        step(NOP, 1'b0);
        check_out("t7.issued", 1'b0, 1'b1, 14'h0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
